// File: rtl/round_pkg.sv
// Shared state type and default sizing for the sparse-term round sequencer.
// Each round always issues TOTAL_WORDS words, so round timing does not depend on the sparse offset.
package round_pkg;

    localparam int WORD_WIDTH_DEF        = 32;
    localparam int DIFF_WIDTH_DEF        = 6;
    localparam int ADDR_WIDTH_DEF        = 10;
    localparam int NORMAL_WORD_COUNT_DEF = 553;
    localparam int MAX_DIFF_DEF          = 63;

    // Real words, then enough zero padding to cover the largest sparse offset, plus the prefill word.
    function automatic int total_words(input int normal_word_count, input int max_diff);
        return normal_word_count + max_diff + 1;
    endfunction

    localparam int TOTAL_WORDS = total_words(NORMAL_WORD_COUNT_DEF, MAX_DIFF_DEF);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_CAPTURE   = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } round_state_e;

endpackage

// File: rtl/round_addr_gen.sv
// Word counter for one round, plus the clamped read address and the per-word flags derived from it.
// Reads past the last real word keep hitting the last address, so the memory access pattern stays fixed.
module round_addr_gen
    import round_pkg::*;
#(
    parameter int NORMAL_WORD_COUNT = NORMAL_WORD_COUNT_DEF,
    parameter int MAX_DIFF          = MAX_DIFF_DEF,
    parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH:0]   k,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  is_dummy,
    output logic                  is_prefill,
    output logic                  is_last
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         NWC_K      = CW'(NORMAL_WORD_COUNT);
    localparam logic [CW-1:0]         LAST_K     = CW'(total_words(NORMAL_WORD_COUNT, MAX_DIFF) - 1);
    localparam logic [ADDR_WIDTH-1:0] CLAMP_ADDR = ADDR_WIDTH'(NORMAL_WORD_COUNT - 1);

    logic [CW-1:0] k_q;
    logic [CW-1:0] k_d;

    always_comb begin
        k_d = k_q;
        if (clear) begin
            k_d = '0;
        end else if (inc) begin
            k_d = k_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k          = k_q;
    assign is_dummy   = (k_q >= NWC_K);
    assign addr       = is_dummy ? CLAMP_ADDR : k_q[ADDR_WIDTH-1:0];
    assign is_prefill = (k_q == '0);
    assign is_last    = (k_q == LAST_K);

endmodule

// File: rtl/round_sequencer.sv
// Streams the normal polynomial (plus zero padding) into one round block for a single sparse term.
// Word count and per-word timing are independent of the sparse offset, so every round takes the same time.
module round_sequencer
    import round_pkg::*;
#(
    parameter int WORD_WIDTH        = WORD_WIDTH_DEF,
    parameter int NORMAL_WORD_COUNT = NORMAL_WORD_COUNT_DEF,
    parameter int MAX_DIFF          = MAX_DIFF_DEF,
    parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
    parameter int DIFF_WIDTH        = DIFF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIFF_WIDTH-1:0] diff_in,
    input  logic                  high_lat_in,
    input  logic                  low_lat_in,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    output logic [WORD_WIDTH-1:0] rb_word_in,
    output logic                  rb_word_valid,
    output logic                  rb_only_add,
    output logic [DIFF_WIDTH-1:0] rb_normal_sparse_diff,
    output logic                  rb_high_latency,
    output logic                  rb_low_latency,
    input  logic                  rb_word_accepted,
    input  logic                  rb_processing_done,
    output logic                  pair_valid,
    output logic [ADDR_WIDTH:0]   pair_index
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int TOTAL = total_words(NORMAL_WORD_COUNT, MAX_DIFF);

    if (TOTAL >= (2 ** CW)) begin : g_total_check
        $error("round_sequencer: word counter too narrow for NORMAL_WORD_COUNT + MAX_DIFF + 1");
    end

    round_state_e          state_q, state_d;
    logic [DIFF_WIDTH-1:0] diff_q, diff_d;
    logic                  high_lat_q, high_lat_d;
    logic                  low_lat_q, low_lat_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  only_add_q, only_add_d;
    logic                  pair_valid_q, pair_valid_d;
    logic [CW-1:0]         pair_index_q, pair_index_d;

    logic                  k_clear;
    logic                  k_inc;
    logic                  word_finished;
    logic [CW-1:0]         k;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_dummy;
    logic                  is_prefill;
    logic                  is_last;

    round_addr_gen #(
        .NORMAL_WORD_COUNT (NORMAL_WORD_COUNT),
        .MAX_DIFF          (MAX_DIFF),
        .ADDR_WIDTH        (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (k_clear),
        .inc        (k_inc),
        .k          (k),
        .addr       (addr),
        .is_dummy   (is_dummy),
        .is_prefill (is_prefill),
        .is_last    (is_last)
    );

    // An accept and a done in the same ISSUE cycle retire the word at once, still advancing only one word.
    always_comb begin
        state_d       = state_q;
        diff_d        = diff_q;
        high_lat_d    = high_lat_q;
        low_lat_d     = low_lat_q;
        word_d        = word_q;
        only_add_d    = only_add_q;
        pair_valid_d  = 1'b0;
        pair_index_d  = pair_index_q;
        k_clear       = 1'b0;
        k_inc         = 1'b0;
        word_finished = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    diff_d     = diff_in;
                    high_lat_d = high_lat_in;
                    low_lat_d  = low_lat_in;
                    k_clear    = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                word_d     = is_dummy ? '0 : mem_rd_data;
                only_add_d = is_prefill;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (rb_word_accepted) begin
                    state_d       = S_WAIT_DONE;
                    word_finished = rb_processing_done;
                end
            end
            S_WAIT_DONE: begin
                word_finished = rb_processing_done;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (word_finished) begin
            if (!only_add_q) begin
                pair_valid_d = 1'b1;
                pair_index_d = k - CW'(1);
            end
            if (is_last) begin
                state_d = S_FINISH;
            end else begin
                k_inc   = 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            diff_q       <= '0;
            high_lat_q   <= 1'b0;
            low_lat_q    <= 1'b0;
            word_q       <= '0;
            only_add_q   <= 1'b0;
            pair_valid_q <= 1'b0;
            pair_index_q <= '0;
        end else begin
            state_q      <= state_d;
            diff_q       <= diff_d;
            high_lat_q   <= high_lat_d;
            low_lat_q    <= low_lat_d;
            word_q       <= word_d;
            only_add_q   <= only_add_d;
            pair_valid_q <= pair_valid_d;
            pair_index_q <= pair_index_d;
        end
    end

    assign busy                  = (state_q != S_IDLE);
    assign done                  = (state_q == S_FINISH);
    assign mem_rd_en             = (state_q == S_FETCH);
    assign mem_rd_addr           = addr;
    assign rb_word_in            = word_q;
    assign rb_word_valid         = (state_q == S_ISSUE);
    assign rb_only_add           = only_add_q;
    assign rb_normal_sparse_diff = diff_q;
    assign rb_high_latency       = high_lat_q;
    assign rb_low_latency        = low_lat_q;
    assign pair_valid            = pair_valid_q;
    assign pair_index            = pair_index_q;

endmodule
